// File: rtl/instr_encoder.sv
// RV32I instruction encoder: range-checks immediates and packs fields into one word.
// Optional INSTR_ENCODER_ERRCNT_EN adds err_count and err_fmt outputs.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err
`ifdef INSTR_ENCODER_ERRCNT_EN
    ,
    output logic [7:0]  err_count,
    output logic [2:0]  err_fmt
`endif
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_R = 3'b100;
    localparam logic [2:0] FMT_U = 3'b101;

    logic        is_i;
    logic        is_s;
    logic        is_b;
    logic        is_j;
    logic        is_r;
    logic        is_u;
    logic        is_rsv;

    logic        fit12;
    logic        fit13;
    logic        fit21;
    logic        even;

    logic        ok;
    logic [31:0] word;
    logic        accept;
    logic        load;
    logic        reject;
    logic        fire;

    assign is_i   = (fmt == FMT_I);
    assign is_s   = (fmt == FMT_S);
    assign is_b   = (fmt == FMT_B);
    assign is_j   = (fmt == FMT_J);
    assign is_r   = (fmt == FMT_R);
    assign is_u   = (fmt == FMT_U);
    assign is_rsv = fmt[2] & fmt[1];

    // Signed fit: every bit above the field's sign bit must copy it.
    assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);
    assign even  = ~imm[0];

    always_comb begin
        ok   = 1'b0;
        word = 32'h0;
        unique case (1'b1)
            is_i: begin
                ok   = fit12;
                word = {imm[11:0], rs1, funct3, rd, opcode};
            end
            is_s: begin
                ok   = fit12;
                word = {imm[11:5], rs2, rs1, funct3,
                        imm[4:0], opcode};
            end
            is_b: begin
                ok   = fit13 & even;
                word = {imm[12], imm[10:5], rs2, rs1, funct3,
                        imm[4:1], imm[11], opcode};
            end
            is_j: begin
                ok   = fit21 & even;
                word = {imm[20], imm[10:1], imm[11],
                        imm[19:12], rd, opcode};
            end
            is_r: begin
                ok   = 1'b1;
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            is_u: begin
                ok   = ~(|imm[11:0]);
                word = {imm[31:12], rd, opcode};
            end
            is_rsv: begin
                ok   = 1'b0;
                word = 32'h0;
            end
            default: begin
                ok   = 1'b0;
                word = 32'h0;
            end
        endcase
    end

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign load     = accept & ok;
    assign reject   = accept & ~ok;
    assign fire     = out_valid & out_ready;

    // clear shares the reset path, so a request in a clear cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_addr  <= BASE_ADDR;
            err       <= 1'b0;
        end else begin
            out_valid <= load | (out_valid & ~out_ready);
            if (load) begin
                out_instr <= word;
            end
            if (fire) begin
                out_addr <= out_addr + 32'd4;
            end
            if (reject) begin
                err <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENCODER_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_count <= 8'd0;
            err_fmt   <= 3'd0;
        end else if (reject) begin
            err_fmt <= fmt;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule
